// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register and one-entry skid; one fetch outstanding, ack->IF/ID in 1 cycle.
// Stall holds IF/ID and parks a returning response in the skid; redirect flushes and kills any pending fetch.
module fetch_stage #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_stall,
  input  logic                   iw_redirect,
  input  logic [ADDR_WIDTH-1:0]  iw_redirect_pc,
  output logic                   ow_imem_req,
  output logic [ADDR_WIDTH-1:0]  ow_imem_addr,
  input  logic                   iw_imem_ack,
  input  logic [INSTR_WIDTH-1:0] iw_imem_data,
  output logic                   ow_valid,
  output logic [ADDR_WIDTH-1:0]  ow_pc,
  output logic [INSTR_WIDTH-1:0] ow_instr
);

  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  pc, pc_nxt, addr_nxt;
  logic                   skid_vld, skid_vld_nxt;
  logic [ADDR_WIDTH-1:0]  skid_pc, skid_pc_nxt;
  logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_nxt;
  logic                   valid_nxt;
  logic [ADDR_WIDTH-1:0]  out_pc_nxt;
  logic [INSTR_WIDTH-1:0] out_instr_nxt;
  logic                   ack, accept;

  assign ow_imem_req = (state != IDLE);

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ow_imem_addr <= RESET_PC;
      skid_vld     <= 1'b0;
      skid_pc      <= '0;
      skid_instr   <= '0;
      ow_valid     <= 1'b0;
      ow_pc        <= '0;
      ow_instr     <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      ow_imem_addr <= addr_nxt;
      skid_vld     <= skid_vld_nxt;
      skid_pc      <= skid_pc_nxt;
      skid_instr   <= skid_instr_nxt;
      ow_valid     <= valid_nxt;
      ow_pc        <= out_pc_nxt;
      ow_instr     <= out_instr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    addr_nxt       = ow_imem_addr;
    skid_vld_nxt   = skid_vld;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    valid_nxt      = ow_valid;
    out_pc_nxt     = ow_pc;
    out_instr_nxt  = ow_instr;
    ack            = iw_imem_ack && (state != IDLE);
    accept         = iw_imem_ack && (state == WAIT) && !iw_redirect;

    if (iw_redirect) begin
      // A response landing in the redirect cycle is simply dropped.
      valid_nxt    = 1'b0;
      skid_vld_nxt = 1'b0;
      pc_nxt       = iw_redirect_pc;
      case (state)
        WAIT:    state_nxt = ack ? IDLE : KILL;
        KILL:    state_nxt = ack ? IDLE : KILL;
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: if (!skid_vld) begin
          state_nxt = WAIT;
          addr_nxt  = pc;
        end
        WAIT: if (ack) begin
          state_nxt = IDLE;
          pc_nxt    = pc + ADDR_WIDTH'(1);
        end
        KILL: if (ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase

      // Skid and a fresh response never coexist: req only rises with skid empty.
      if (!iw_stall) begin
        if (skid_vld) begin
          valid_nxt     = 1'b1;
          out_pc_nxt    = skid_pc;
          out_instr_nxt = skid_instr;
          skid_vld_nxt  = 1'b0;
        end else if (accept) begin
          valid_nxt     = 1'b1;
          out_pc_nxt    = ow_imem_addr;
          out_instr_nxt = iw_imem_data;
        end else begin
          valid_nxt = 1'b0;
        end
      end else if (accept) begin
        skid_vld_nxt   = 1'b1;
        skid_pc_nxt    = ow_imem_addr;
        skid_instr_nxt = iw_imem_data;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID output register, directly upstream of decode and the hazard unit.
- Consumes the hazard unit's stall (hold) and EX's branch redirect.
- Drives a single-outstanding req/ack instruction-memory port and presents {valid, pc, instr} to decode.
- A one-entry skid buffer catches a fetch response that returns while decode is stalled.

Parameters:
- ADDR_WIDTH, 24, PC / imem address width (word-addressed)
- INSTR_WIDTH, 24, instruction word width
- RESET_PC, 0, first fetch address after reset

Ports:
- iw_clk  in  1  clock; all state on rising edge
- iw_rst  in  1  reset, synchronous, active-high
- iw_stall  in  1  hold IF/ID register (from hazard unit)
- iw_redirect  in  1  flush and refetch from iw_redirect_pc
- iw_redirect_pc  in  ADDR_WIDTH  redirect target
- ow_imem_req  out  1  fetch request, registered
- ow_imem_addr  out  ADDR_WIDTH  fetch address, registered, stable while req high
- iw_imem_ack  in  1  response valid; only meaningful while req high
- iw_imem_data  in  INSTR_WIDTH  instruction word, valid with ack
- ow_valid  out  1  IF/ID holds a live instruction
- ow_pc  out  ADDR_WIDTH  PC of ow_instr
- ow_instr  out  INSTR_WIDTH  fetched instruction

Behaviour:
- Reset (sync, active-high), values visible the cycle after the reset edge:
  - ow_imem_req=0, ow_imem_addr=RESET_PC, ow_valid=0, ow_pc=0, ow_instr=0
  - pc=RESET_PC, skid empty, state IDLE
- Reset mid-request withdraws req; imem must tolerate this.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - KILL: request outstanding, response to be dropped.
  - ow_imem_req = (state != IDLE).
- IDLE -> WAIT when skid empty and !iw_redirect: ow_imem_addr <= pc.
- WAIT + ack -> IDLE: response accepted, pc <= pc+1, wrapping modulo 2^ADDR_WIDTH.
- KILL + ack -> IDLE: response dropped, pc unchanged.
- Request protocol: once raised, req and addr are held until ack. Never withdrawn except by reset. Ack may come the cycle req is first seen high (zero-wait).
- Minimum throughput: one instruction per 2 cycles (IDLE→WAIT→ack).
- Accepted response routing (WAIT+ack), decided in the ack cycle:
  - !iw_stall and skid empty → IF/ID <= {1, ow_imem_addr, data}.
  - iw_stall → skid <= {addr, data}.
- IF/ID update when !iw_stall:
  - Load skid if skid valid (skid cleared), else load the accepted response, else ow_valid <= 0 (bubble).
  - Skid and ack cannot both be present: req is only raised with skid empty.
- IF/ID when iw_stall: ow_valid/ow_pc/ow_instr hold exactly.
- Latency: ack in cycle N, not stalled → ow_valid=1 in N+1.
- Redirect (priority over stall and normal operation):
  - ow_valid <= 0, skid cleared, pc <= iw_redirect_pc.
  - WAIT without ack this cycle → KILL.
  - WAIT with ack this cycle → response dropped, → IDLE.
  - IDLE → stays IDLE this cycle.
  - KILL → stays KILL.
- Redirect while in KILL: pc takes the newest target.
- Simultaneous redirect + stall: redirect wins; IF/ID is cleared even though stalled.

Test Plan:
- Reset release, imem acks every request immediately:
  - req rises the cycle after reset, addr 0,1,2,…
  - ow_valid pulses with ow_pc=0,1,2 every 2 cycles; instr matches the data returned.
- Stall 3 cycles while addr 5 is outstanding, ack with data 0xABCDEF during the stall:
  - IF/ID holds its prior contents.
  - 0xABCDEF lands in skid; no new req issued.
  - First unstalled cycle: ow_pc=5, ow_instr=0xABCDEF; req for addr 6 follows.
- Redirect to 0x100 while req for addr 7 is pending, ack arrives 2 cycles later:
  - addr 7 response is dropped, ow_valid stays 0.
  - Next req has addr 0x100; ow_pc=0x100 appears next.
- Redirect to 0x40 in the same cycle as ack for addr 9:
  - addr 9 never appears on IF/ID.
  - Next req addr is 0x40.
- Redirect to 0x20 asserted together with stall while IF/ID and skid are both full:
  - Next cycle ow_valid=0 and skid is empty.
  - First output after the stall clears is ow_pc=0x20.
- pc=0xFFFFFF accepted:
  - Next req addr is 0x000000 (wrap).
- Reset asserted while req high:
  - Next cycle req=0, ow_valid=0, pc=RESET_PC; a late ack is ignored.
